ctrl_packet_initiator: RTL and testbench
========================================

CTRL_PACKET_INITIATOR -- requirements
Module: ctrl_packet_initiator

Interface
REQ-001 Parameters; DATA_WIDTH is a multiple of 32:
- DATA_WIDTH, 512, forward data bus width.
- STREAM_ID_NUM, 16, number of virtual streams.
- CHUNK_ID_NUM, 32, number of chunk IDs.
- CHANNEL_ID_NUM, 1024, number of virtual channels.
- STATE_WIDTH, 32, state/address field width (≥32).
- CTRL_STREAM_ID, 0, StreamID stamped on issued packets.
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before a read is abandoned.
- Derived: STREAM_ID_WIDTH, CHUNK_ID_WIDTH and CHANNEL_ID_WIDTH are $clog2 of the matching *_NUM; NUM_32B_FIELDS = DATA_WIDTH/32.

REQ-002 One clock; reset is asynchronous and active-low. Ports (name direction width meaning):
- clk  in  1  clock.
- rstn  in  1  async active-low reset.
- Cmd_Valid  in  1  host command valid.
- Cmd_Ready  out  1  host command ready.
- Cmd_Write  in  1  1 = write, 0 = read.
- Cmd_Hop  in  CHANNEL_ID_WIDTH  target module index along chain (0 = first).
- Cmd_Addr  in  32  register address.
- Cmd_WData  in  32  write value.
- Rsp_Valid  out  1  one-cycle completion pulse.
- Rsp_RData  out  32  read value (0 for writes and timeouts).
- Rsp_Timeout  out  1  qualifies Rsp_Valid; read abandoned.
- Stat_Stale  out  16  saturating count of unmatched read responses.
- Back_Data / Back_Type / Back_Last / Back_StreamID / Back_ChunkID / Back_ChannelID / Back_State  out  standard forward widths  issued packet toward chain.
- Front_Type / Front_ChunkID / Front_State / Front_Data  in  standard forward widths  return path from chain end.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE; Cmd_Ready = 1 only in IDLE.
REQ-004 A command accepted (Cmd_Valid & Cmd_Ready) at edge N SHALL present one packet on Back_* during cycle N+1 (state ISSUE), with:
- Type = 2'b10, Last = 1.
- StreamID = CTRL_STREAM_ID.
- ChunkID = {1'b1, code}, code = 1 for write, 0 for read.
- ChannelID = Cmd_Hop.
- State = Cmd_Addr zero-extended.
- Data = Cmd_WData replicated NUM_32B_FIELDS times for writes; all zero for reads.
REQ-005 Back_Type SHALL be 0 in every cycle other than ISSUE; the other Back_* fields hold their last value.
REQ-006 A write SHALL go ISSUE→DONE, so Rsp_Valid = 1 with Rsp_RData = 0 and Rsp_Timeout = 0 at N+2; the FSM returns to IDLE at N+3.
REQ-007 A read SHALL go ISSUE→WAIT, latching the address and clearing the timeout counter.
REQ-008 In WAIT, a matching response is Front_Type[1] = 1, Front_ChunkID MSB = 0, Front_ChunkID low bits = 1 (CTRL_READ_RESPONSE_32b) and Front_State = latched address.
REQ-009 A match in cycle M SHALL give DONE at M+1, with Rsp_Valid = 1, Rsp_RData = Front_Data[31:0] and Rsp_Timeout = 0.
REQ-010 The WAIT counter SHALL increment every cycle. If it reaches TIMEOUT_CYCLES-1 without a match, the next state is DONE with Rsp_Timeout = 1 and Rsp_RData = 0.
REQ-011 A match in the same cycle as the timeout SHALL win.
REQ-012 Stat_Stale SHALL increment, saturating at 16'hFFFF, for each CTRL_READ_RESPONSE_32b on Front_* that is not a match. This includes responses seen in IDLE, ISSUE and DONE.
REQ-013 Front_* packets of data type or with any other control code SHALL be ignored.
REQ-014 Cmd_Valid in non-IDLE states SHALL be ignored; the command is not latched.

Reset
REQ-015 While rstn = 0:
- State = IDLE, Cmd_Ready = 0.
- Back_Type = 0; all other Back_* = 0.
- Rsp_Valid = 0, Rsp_RData = 0, Rsp_Timeout = 0.
- Stat_Stale = 0.
REQ-016 Cmd_Ready SHALL rise in the first cycle after rstn deasserts.
REQ-017 Reset in WAIT or DONE SHALL abandon the command with no Rsp_Valid pulse.

Structure
REQ-018 Shared package: control-packet codes (CP_A_*, CP_R_*), instruction encodings, and Type bit positions (bit1 = control, bit0 = data).
REQ-019 The WAIT counter SHALL be the sub-module ctrl_timeout_counter (clear, enable, expire); the FSM stays in the top.

Verification
REQ-020 Write, hop 3, addr 0x10, wdata 0xDEADBEEF -> at N+1:
- Back_Type = 2'b10, ChunkID = 5'b10001, ChannelID = 3, State = 0x10.
- Back_Data = 16 copies of 0xDEADBEEF.
- Rsp_Valid at N+2 with RData = 0.
REQ-021 Read, hop 0, addr 0x24; response with State 0x24, Data[31:0] = 0x1234 injected 5 cycles later -> Rsp_Valid with RData = 0x1234, Timeout = 0.
REQ-022 Read with no response, TIMEOUT_CYCLES = 8 -> Rsp_Valid with Timeout = 1 exactly 8 cycles after ISSUE; Cmd_Ready returns to 1 one cycle later.
REQ-023 Read addr 0x24 in WAIT; response with State 0x28, then one with State 0x24 -> Stat_Stale = 1 and RData taken from the second response.
REQ-024 rstn pulsed low mid-WAIT, then the matching response arrives -> no Rsp_Valid, Stat_Stale = 1, Cmd_Ready = 1.

Source files
------------

// File: rtl/ctrl_packet_initiator_pkg.sv
// Shared definitions for the control-packet initiator: FSM states, packet
// Type bit positions and the control-packet codes carried in ChunkID.
package ctrl_packet_initiator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } fsm_state_t;

  // Type field: bit1 marks a control packet, bit0 a data packet.
  localparam int TYPE_CTRL_BIT = 1;
  localparam int TYPE_DATA_BIT = 0;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_CTRL = 2'b10;

  // ChunkID MSB tells requests (towards the chain) from responses (back).
  localparam logic CHUNK_DIR_REQUEST  = 1'b1;
  localparam logic CHUNK_DIR_RESPONSE = 1'b0;

  // Request codes (ChunkID low bits when the MSB is CHUNK_DIR_REQUEST).
  localparam int CP_A_READ_32B  = 0;
  localparam int CP_A_WRITE_32B = 1;

  // Response codes (ChunkID low bits when the MSB is CHUNK_DIR_RESPONSE).
  localparam int CP_R_WRITE_ACK_32B      = 0;
  localparam int CP_R_READ_RESPONSE_32B  = 1;

  // True when a Type field carries a control packet.
  function automatic logic is_ctrl_type(input logic [1:0] pkt_type);
    return pkt_type[TYPE_CTRL_BIT];
  endfunction

endpackage

// File: rtl/ctrl_packet_initiator_timeout.sv
// Cycle counter guarding the WAIT state of the initiator. Cleared while the
// read request is on the bus, counts every WAIT cycle, and flags expiry in
// the cycle where the count steps onto TIMEOUT_CYCLES-1, so the FSM reaches
// DONE exactly TIMEOUT_CYCLES cycles after the request was issued.
module ctrl_timeout_counter #(
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // Counter register: clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/ctrl_packet_initiator.sv
// Host-side initiator for register accesses along a module chain. Each host
// command becomes one control packet on Back_*; writes complete right after
// issue, reads wait for a matching read response on Front_* or time out.
// Read responses that do not match the outstanding read are counted.
module ctrl_packet_initiator
  import ctrl_packet_initiator_pkg::*;
#(
  parameter  int DATA_WIDTH       = 512,
  parameter  int STREAM_ID_NUM    = 16,
  parameter  int CHUNK_ID_NUM     = 32,
  parameter  int CHANNEL_ID_NUM   = 1024,
  parameter  int STATE_WIDTH      = 32,
  parameter  int CTRL_STREAM_ID   = 0,
  parameter  int TIMEOUT_CYCLES   = 1024,
  localparam int STREAM_ID_WIDTH  = $clog2(STREAM_ID_NUM),
  localparam int CHUNK_ID_WIDTH   = $clog2(CHUNK_ID_NUM),
  localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM),
  localparam int NUM_32B_FIELDS   = DATA_WIDTH / 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        Cmd_Valid,
  output logic                        Cmd_Ready,
  input  logic                        Cmd_Write,
  input  logic [CHANNEL_ID_WIDTH-1:0] Cmd_Hop,
  input  logic [31:0]                 Cmd_Addr,
  input  logic [31:0]                 Cmd_WData,
  output logic                        Rsp_Valid,
  output logic [31:0]                 Rsp_RData,
  output logic                        Rsp_Timeout,
  output logic [15:0]                 Stat_Stale,
  output logic [DATA_WIDTH-1:0]       Back_Data,
  output logic [1:0]                  Back_Type,
  output logic                        Back_Last,
  output logic [STREAM_ID_WIDTH-1:0]  Back_StreamID,
  output logic [CHUNK_ID_WIDTH-1:0]   Back_ChunkID,
  output logic [CHANNEL_ID_WIDTH-1:0] Back_ChannelID,
  output logic [STATE_WIDTH-1:0]      Back_State,
  input  logic [1:0]                  Front_Type,
  input  logic [CHUNK_ID_WIDTH-1:0]   Front_ChunkID,
  input  logic [STATE_WIDTH-1:0]      Front_State,
  input  logic [DATA_WIDTH-1:0]       Front_Data
);

  localparam int CODE_W = CHUNK_ID_WIDTH - 1;

  fsm_state_t             state;
  logic                   is_write;
  logic [STATE_WIDTH-1:0] rd_addr;
  logic                   cnt_clear;
  logic                   cnt_enable;
  logic                   cnt_expire;
  logic                   rd_response;
  logic                   rd_match;
  logic                   stale_event;
  logic                   unused_front;

  // A read response is a control packet whose ChunkID carries the response
  // direction and the read-response code; anything else on Front_* is ignored.
  assign rd_response = is_ctrl_type(Front_Type)
                    && (Front_ChunkID[CHUNK_ID_WIDTH-1] == CHUNK_DIR_RESPONSE)
                    && (Front_ChunkID[CODE_W-1:0] == CODE_W'(CP_R_READ_RESPONSE_32B));
  assign rd_match    = rd_response && (state == S_WAIT) && (Front_State == rd_addr);
  assign stale_event = rd_response && !rd_match;

  // Only the low word of a response is returned; the data-type bit plays no
  // part once the control bit has been checked.
  assign unused_front = ^{Front_Type[TYPE_DATA_BIT], Front_Data[DATA_WIDTH-1:32]};

  assign cnt_clear  = (state == S_ISSUE);
  assign cnt_enable = (state == S_WAIT);

  ctrl_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rstn),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expire (cnt_expire)
  );

  // Command FSM with registered handshake, packet and response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      is_write       <= 1'b0;
      rd_addr        <= '0;
      Cmd_Ready      <= 1'b0;
      Rsp_Valid      <= 1'b0;
      Rsp_RData      <= '0;
      Rsp_Timeout    <= 1'b0;
      Back_Data      <= '0;
      Back_Type      <= TYPE_NONE;
      Back_Last      <= 1'b0;
      Back_StreamID  <= '0;
      Back_ChunkID   <= '0;
      Back_ChannelID <= '0;
      Back_State     <= '0;
    end else begin
      // NOTE: one-cycle outputs take a default here and are overridden
      // below, so no branch can leave them asserted by omission.
      Rsp_Valid   <= 1'b0;
      Rsp_Timeout <= 1'b0;
      Back_Type   <= TYPE_NONE;

      case (state)
        S_IDLE: begin
          Cmd_Ready <= 1'b1;
          if (Cmd_Valid && Cmd_Ready) begin
            state          <= S_ISSUE;
            Cmd_Ready      <= 1'b0;
            is_write       <= Cmd_Write;
            Back_Type      <= TYPE_CTRL;
            Back_Last      <= 1'b1;
            Back_StreamID  <= STREAM_ID_WIDTH'(CTRL_STREAM_ID);
            Back_ChunkID   <= {CHUNK_DIR_REQUEST,
                               Cmd_Write ? CODE_W'(CP_A_WRITE_32B) : CODE_W'(CP_A_READ_32B)};
            Back_ChannelID <= Cmd_Hop;
            Back_State     <= STATE_WIDTH'(Cmd_Addr);
            Back_Data      <= Cmd_Write ? {NUM_32B_FIELDS{Cmd_WData}} : '0;
          end
        end

        S_ISSUE: begin
          if (is_write) begin
            state     <= S_DONE;
            Rsp_Valid <= 1'b1;
            Rsp_RData <= '0;
          end else begin
            state   <= S_WAIT;
            rd_addr <= Back_State;
          end
        end

        S_WAIT: begin
          // A response arriving in the expiry cycle still completes the read.
          if (rd_match) begin
            state     <= S_DONE;
            Rsp_Valid <= 1'b1;
            Rsp_RData <= Front_Data[31:0];
          end else if (cnt_expire) begin
            state       <= S_DONE;
            Rsp_Valid   <= 1'b1;
            Rsp_RData   <= '0;
            Rsp_Timeout <= 1'b1;
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          Cmd_Ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          Cmd_Ready <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of read responses that do not complete the pending read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      Stat_Stale <= '0;
    end else if (stale_event && (Stat_Stale != 16'hFFFF)) begin
      Stat_Stale <= Stat_Stale + 16'd1;
    end
  end

endmodule

// File: tb/tb_ctrl_packet_initiator.sv
// Scoreboard bench for ctrl_packet_initiator: the stimulus side predicts each
// packet and completion from the command rules and queues them; monitors
// compare whatever the DUT presents against the queue heads.
module tb_ctrl_packet_initiator;

  localparam int DW  = 512;
  localparam int CHW = 10;
  localparam int T   = 8;

  typedef struct {
    int          cyc;
    logic [CHW-1:0] hop;
    logic [4:0]  chunk;
    logic [31:0] state;
    logic [DW-1:0] data;
  } pkt_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        timeout;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic           Cmd_Valid;
  logic           Cmd_Ready;
  logic           Cmd_Write;
  logic [CHW-1:0] Cmd_Hop;
  logic [31:0]    Cmd_Addr;
  logic [31:0]    Cmd_WData;
  logic           Rsp_Valid;
  logic [31:0]    Rsp_RData;
  logic           Rsp_Timeout;
  logic [15:0]    Stat_Stale;
  logic [DW-1:0]  Back_Data;
  logic [1:0]     Back_Type;
  logic           Back_Last;
  logic [3:0]     Back_StreamID;
  logic [4:0]     Back_ChunkID;
  logic [CHW-1:0] Back_ChannelID;
  logic [31:0]    Back_State;
  logic [1:0]     Front_Type;
  logic [4:0]     Front_ChunkID;
  logic [31:0]    Front_State;
  logic [DW-1:0]  Front_Data;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   exp_stale = 0;
  pkt_t pkt_q[$];
  rsp_t rsp_q[$];
  pkt_t mon_p;
  rsp_t mon_r;

  ctrl_packet_initiator #(
    .DATA_WIDTH     (DW),
    .STREAM_ID_NUM  (16),
    .CHUNK_ID_NUM   (32),
    .CHANNEL_ID_NUM (1024),
    .STATE_WIDTH    (32),
    .CTRL_STREAM_ID (0),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .Cmd_Valid      (Cmd_Valid),
    .Cmd_Ready      (Cmd_Ready),
    .Cmd_Write      (Cmd_Write),
    .Cmd_Hop        (Cmd_Hop),
    .Cmd_Addr       (Cmd_Addr),
    .Cmd_WData      (Cmd_WData),
    .Rsp_Valid      (Rsp_Valid),
    .Rsp_RData      (Rsp_RData),
    .Rsp_Timeout    (Rsp_Timeout),
    .Stat_Stale     (Stat_Stale),
    .Back_Data      (Back_Data),
    .Back_Type      (Back_Type),
    .Back_Last      (Back_Last),
    .Back_StreamID  (Back_StreamID),
    .Back_ChunkID   (Back_ChunkID),
    .Back_ChannelID (Back_ChannelID),
    .Back_State     (Back_State),
    .Front_Type     (Front_Type),
    .Front_ChunkID  (Front_ChunkID),
    .Front_State    (Front_State),
    .Front_Data     (Front_Data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference packet: a control request, code 1 for write and 0 for read,
  // write data replicated across the bus, read data zero.
  function automatic pkt_t model_pkt(input bit wr, input logic [CHW-1:0] hop,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input int at);
    pkt_t p;
    p.cyc   = at;
    p.hop   = hop;
    p.chunk = wr ? 5'b10001 : 5'b10000;
    p.state = addr;
    p.data  = '0;
    if (wr) for (int i = 0; i < DW / 32; i++) p.data[i*32 +: 32] = wdata;
    return p;
  endfunction

  task automatic front_idle();
    Front_Type    = 2'b00;
    Front_ChunkID = '0;
    Front_State   = '0;
    Front_Data    = '0;
  endtask

  task automatic front_rd_resp(input logic [31:0] addr, input logic [31:0] data32);
    Front_Type    = 2'b10;
    Front_ChunkID = 5'b00001;
    Front_State   = addr;
    for (int i = 0; i < DW / 32; i++) Front_Data[i*32 +: 32] = $urandom;
    Front_Data[31:0] = data32;
  endtask

  // Packets that must be ignored: data type, another response code, or a
  // request code -- all carrying the pending address.
  task automatic front_noise(input logic [31:0] addr);
    int kind;
    kind = $urandom_range(0, 2);
    Front_State = addr;
    Front_Data  = {16{$urandom}};
    case (kind)
      0:       begin Front_Type = 2'b01; Front_ChunkID = 5'b00001; end
      1:       begin Front_Type = 2'b10; Front_ChunkID = 5'b00010; end
      default: begin Front_Type = 2'b10; Front_ChunkID = 5'b10001; end
    endcase
  endtask

  // One command from acceptance to the first IDLE cycle afterwards.
  // delay: read response offset from the ISSUE cycle (0 = never answered).
  task automatic run_txn(input bit wr, input logic [CHW-1:0] hop, input logic [31:0] addr,
                         input logic [31:0] wdata, input int delay, input bit st_issue,
                         input bit st_w1, input bit noise_w2, input bit st_done,
                         input bit hold_valid, input logic [31:0] rdata);
    int   a, r, m, n;
    rsp_t er;
    n = 0;
    while (Cmd_Ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_cmd", Cmd_Ready, 1);
    Cmd_Valid = 1'b1;
    Cmd_Write = wr;
    Cmd_Hop   = hop;
    Cmd_Addr  = addr;
    Cmd_WData = wdata;
    @(posedge clk);
    @(negedge clk);
    a = cyc;
    pkt_q.push_back(model_pkt(wr, hop, addr, wdata, a));
    m = -1;
    if (wr) r = a + 1;
    else if (delay > 0) begin m = a + delay; r = m + 1; end
    else r = a + T;
    er.cyc     = r;
    er.rdata   = (!wr && delay > 0) ? rdata : 32'h0;
    er.timeout = (!wr && delay == 0);
    rsp_q.push_back(er);
    // A held command during the transaction carries different fields, so an
    // erroneous acceptance would show up as an unexpected packet.
    Cmd_Hop   = ~hop;
    Cmd_Addr  = addr ^ 32'h100;
    Cmd_WData = ~wdata;
    for (int c = a; c <= r + 1; c++) begin
      if (c != a) @(negedge clk);
      Cmd_Valid = hold_valid && (c < r);
      if (c <= r) check("ready_low_busy", Cmd_Ready, 0);
      if (c == r + 1) begin
        front_idle();
        check("ready_after_done", Cmd_Ready, 1);
        check("stat_stale", Stat_Stale, exp_stale);
      end else if (c == m) begin
        front_rd_resp(addr, rdata);
      end else if (c == a && st_issue) begin
        front_rd_resp(addr, $urandom);
        exp_stale++;
      end else if (c == a + 1 && st_w1) begin
        front_rd_resp(addr + 32'h4, $urandom);
        exp_stale++;
      end else if (c == a + 2 && noise_w2) begin
        front_noise(addr);
      end else if (c == r && st_done) begin
        front_rd_resp(addr, $urandom);
        exp_stale++;
      end else begin
        front_idle();
      end
    end
    Cmd_Valid = 1'b0;
  endtask

  // Packet monitor.
  always @(negedge clk) begin
    if (rstn === 1'b1 && Back_Type !== 2'b00) begin
      if (pkt_q.size() == 0) begin
        check("unexpected_packet", Back_Type, 2'b00);
      end else begin
        mon_p = pkt_q.pop_front();
        check("pkt_cycle", cyc, mon_p.cyc);
        check("pkt_type", Back_Type, 2'b10);
        check("pkt_last", Back_Last, 1);
        check("pkt_stream", Back_StreamID, 0);
        check("pkt_chunk", Back_ChunkID, mon_p.chunk);
        check("pkt_channel", Back_ChannelID, mon_p.hop);
        check("pkt_state", Back_State, mon_p.state);
        check("pkt_data", Back_Data, mon_p.data);
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (rstn === 1'b1 && Rsp_Valid !== 1'b0) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", Rsp_Valid, 0);
      end else begin
        mon_r = rsp_q.pop_front();
        check("rsp_cycle", cyc, mon_r.cyc);
        check("rsp_rdata", Rsp_RData, mon_r.rdata);
        check("rsp_timeout", Rsp_Timeout, mon_r.timeout);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rstn      = 1'b0;
    Cmd_Valid = 1'b0;
    Cmd_Write = 1'b0;
    Cmd_Hop   = '0;
    Cmd_Addr  = '0;
    Cmd_WData = '0;
    front_idle();
    repeat (3) @(negedge clk);
    check("reset_ready", Cmd_Ready, 0);
    check("reset_back_type", Back_Type, 0);
    check("reset_back_data", Back_Data, 0);
    check("reset_back_chunk", Back_ChunkID, 0);
    check("reset_back_channel", Back_ChannelID, 0);
    check("reset_back_state", Back_State, 0);
    check("reset_back_last", Back_Last, 0);
    check("reset_rsp_valid", Rsp_Valid, 0);
    check("reset_rsp_rdata", Rsp_RData, 0);
    check("reset_rsp_timeout", Rsp_Timeout, 0);
    check("reset_stale", Stat_Stale, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", Cmd_Ready, 1);

    // Directed cases: write, answered read, timeout, stale-then-match,
    // match in the expiry cycle, and stale responses outside WAIT.
    run_txn(1'b1, 10'd3, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 32'h0);
    run_txn(1'b0, 10'd0, 32'h24, 32'h0, 5, 0, 0, 0, 0, 0, 32'h1234);
    run_txn(1'b0, 10'd7, 32'h40, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
    run_txn(1'b0, 10'd0, 32'h24, 32'h0, 4, 0, 1, 0, 0, 0, 32'h5678);
    run_txn(1'b0, 10'd1, 32'h80, 32'h0, T - 1, 0, 0, 1, 0, 1, 32'hA5A5A5A5);
    run_txn(1'b0, 10'd2, 32'h90, 32'h0, 1, 1, 0, 0, 1, 0, 32'h0BADF00D);
    run_txn(1'b1, 10'd1023, 32'hFFFFFFFC, 32'h01234567, 0, 1, 0, 0, 1, 1, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        front_rd_resp($urandom, $urandom);
        exp_stale++;
        @(negedge clk);
        front_idle();
      end
      run_txn($urandom_range(0, 1) == 1, CHW'($urandom), $urandom, $urandom,
              $urandom_range(0, T - 1),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, $urandom);
    end

    // Reset in WAIT: the read is abandoned and its late answer counts as stale.
    Cmd_Valid = 1'b1;
    Cmd_Write = 1'b0;
    Cmd_Hop   = 10'd5;
    Cmd_Addr  = 32'h24;
    @(posedge clk);
    @(negedge clk);
    a = cyc;
    pkt_q.push_back(model_pkt(1'b0, 10'd5, 32'h24, 32'h0, a));
    Cmd_Valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midwait_reset_ready", Cmd_Ready, 0);
    check("midwait_reset_type", Back_Type, 0);
    check("midwait_reset_state", Back_State, 0);
    check("midwait_reset_valid", Rsp_Valid, 0);
    check("midwait_reset_stale", Stat_Stale, 0);
    exp_stale = 0;
    @(negedge clk);
    rstn = 1'b1;
    front_rd_resp(32'h24, 32'h1234);
    exp_stale++;
    @(negedge clk);
    front_idle();
    check("post_reset_stale", Stat_Stale, exp_stale);
    check("post_reset_ready", Cmd_Ready, 1);
    repeat (T + 4) @(negedge clk);

    check("pkt_queue_empty", pkt_q.size(), 0);
    check("rsp_queue_empty", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
